vga_timing_gen: RTL
===================

# vga_timing_gen

Parametrised VGA timing and pixel-pipeline generator. It drives the video DAC and the sync pins directly from `CLOCK_50`. The pixel rate comes from a programmable clock-enable divider, so no derived clock drives internal logic. Per-pixel coordinates go to the drawing/control logic, and the colour it returns is accepted after a configurable pipeline latency. Sync and blank are delayed to match, so the colour always lands on the correct pixel.

## Interface
- `H_SYNC`, 96, horizontal sync width in pixels
- `H_BACK`, 48, horizontal back porch
- `H_ACTIVE`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch
- `V_SYNC`, 2, vertical sync width in lines
- `V_BACK`, 33, vertical back porch
- `V_ACTIVE`, 480, visible lines
- `V_FRONT`, 10, vertical front porch
- `CLK_DIV`, 2, `CLOCK_50` cycles per pixel; legal values are 2 to 16
- `COLOR_BITS`, 2, colour input bits per channel; legal values are 1 to 8
- `PIPE_LAT`, 1, pixel ticks from coordinate to colour input; legal values are 0 to 4
- `HS_POL`, 0, active level of `VGA_HS`
- `VS_POL`, 0, active level of `VGA_VS`

- `CLOCK_50`  in  1  system clock; all state is on its rising edge
- `reset`  in  1  asynchronous, active-low reset
- `enable`  in  1  run (1) or hold the raster at its origin (0)
- `R`, `G`, `B`  in  `COLOR_BITS` each  colour for the pixel requested `PIPE_LAT` ticks earlier
- `pix_ce`  out  1  one-`CLOCK_50`-cycle pixel tick
- `x`, `y`  out  11 each  requested pixel coordinate; all-ones outside the active area
- `active`  out  1  (`x`,`y`) is visible
- `line_start`, `frame_start`  out  1  high during the tick in which h=0 (`frame_start`: h=0 and v=0)
- `VGA_CLK`  out  1  pixel clock to the DAC
- `VGA_R`, `VGA_G`, `VGA_B`  out  8 each  DAC colour
- `VGA_HS`, `VGA_VS`, `VGA_BLANK_N`, `VGA_SYNC_N`  out  1  sync/blank pins; `VGA_SYNC_N` is tied to 1

## Operation

**Clock divider**
- Divider `div` counts 0 to `CLK_DIV`-1 and wraps.
- `pix_ce` = (`div` == `CLK_DIV`-1).
- `VGA_CLK` = (`div` >= `CLK_DIV`/2), registered. Outputs therefore change away from the DAC's rising edge.

**Raster counters** (advance only on `pix_ce`)
- `h` counts 0 to H_TOT-1, where H_TOT = sum of the four `H_*` parameters. At wrap, `v` increments.
- `v` counts 0 to V_TOT-1 and wraps to 0.
- Region order within each axis is sync, back porch, active, front porch.
- `active` = (h in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE)) and (v in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_ACTIVE)).
- `x` = h − (H_SYNC+H_BACK) and `y` = v − (V_SYNC+V_BACK) when inside the active region, otherwise 11'h7FF. Both are registered together with `h`/`v`.

**Output stage**
- Active, h-sync and v-sync pass through a `PIPE_LAT`-deep shift register clocked by `pix_ce`, then a final output register.
- Each colour channel is widened to 8 bits by bit replication. Example: `COLOR_BITS`=2, value 2'b01 gives 8'b01010101.
- When the delayed active is 0, colours are forced to 0 and `VGA_BLANK_N`=0.

**enable**
- While 0: `h`/`v` are held at 0, `x`/`y` read all-ones, and the pipeline keeps shifting blanked, inactive-sync pixels. The divider keeps running.
- On the first tick after `enable` rises: `frame_start`=1.

**Reset**
- Asynchronous, independent of `pix_ce`.
- Reset values:
  - `div`, `h`, `v`, `VGA_CLK`, `pix_ce`, `active`, `line_start`, `frame_start` = 0.
  - `x`, `y` = 7FF.
  - `VGA_R`/`G`/`B` = 0, `VGA_BLANK_N` = 0.
  - `VGA_HS` = ~`HS_POL`, `VGA_VS` = ~`VS_POL`, all pipeline stages = blank.
- Reset mid-frame abandons the frame; no partial-line recovery is attempted.

## Timing
- Tick n is the `CLOCK_50` cycle with `pix_ce`=1 and counters at position p.
- During tick n: `x`, `y`, `active`, `line_start`, `frame_start` describe pixel p.
- `R`/`G`/`B` for pixel p are sampled at the end of tick n+`PIPE_LAT`.
- `VGA_*` show pixel p for the whole pixel period following tick n+`PIPE_LAT`, including sync and blank.
- With `PIPE_LAT`=0, colour must be valid combinationally during tick n.
- First `pix_ce` after reset release: `CLOCK_50` cycle `CLK_DIV`.
- Frame period = H_TOT·V_TOT·`CLK_DIV` `CLOCK_50` cycles.

## Configuration
- `VGA_TIMING_GEN_TESTPAT_EN`
  - **Defined:** adds input `test_mode` (1 bit). When `test_mode`=1, `R`/`G`/`B` are ignored and 8 vertical colour bars of width `H_ACTIVE`/8 are generated. Bar index i = x/(`H_ACTIVE`/8); `VGA_R`=i[2]?FF:00, `VGA_G`=i[1]?FF:00, `VGA_B`=i[0]?FF:00. The bars use the same latency and blanking as normal colour.
  - **Undefined:** no `test_mode` port and no bar logic; colour always comes from `R`/`G`/`B`.

## Test plan
- Defaults, 2 frames:
  - `VGA_HS` low for 192 of every 1600 `CLOCK_50` cycles.
  - `VGA_VS` low for 2 of every 525 lines.
  - `frame_start` period is 840000 cycles.
- Active window:
  - 307200 ticks with `active`=1 per frame.
  - First active tick at h=144, v=35 with `x`=0, `y`=0; last at `x`=639, `y`=479.
  - `x`=7FF at h=143.
- `PIPE_LAT`=2, R=x[1:0]:
  - Pixel x=1 gives `VGA_R`=8'h55 in the pixel period after tick n+2.
  - R=3 during blanking gives `VGA_R`=0 and `VGA_BLANK_N`=0.
- Async reset at h=300, v=200, asserted mid-cycle:
  - All outputs reach reset values before the next edge.
  - After release, the first `pix_ce` comes at the 2nd `CLOCK_50` cycle with `frame_start`=1.
- `enable` low mid-line for 1000 ticks:
  - `VGA_HS`=`VGA_VS`=1 and `VGA_BLANK_N`=0 throughout.
  - On re-enable, `frame_start`=1 on the next tick.
- `VGA_TIMING_GEN_TESTPAT_EN` defined, `test_mode`=1:
  - x=80 gives R=00, G=00, B=FF.
  - x=639 gives R=G=B=FF.

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing with a clock-enable pixel divider and a
// latency-matched output stage for sync, blank and colour.
// Optional build macro VGA_TIMING_GEN_TESTPAT_EN adds a test_mode input that
// replaces R/G/B with eight vertical colour bars.
module vga_timing_gen #(
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BACK     = 48,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FRONT    = 16,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BACK     = 33,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FRONT    = 10,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned COLOR_BITS = 2,
  parameter int unsigned PIPE_LAT   = 1,
  parameter logic        HS_POL     = 1'b0,
  parameter logic        VS_POL     = 1'b0
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [COLOR_BITS-1:0] R,
  input  logic [COLOR_BITS-1:0] G,
  input  logic [COLOR_BITS-1:0] B,
`ifdef VGA_TIMING_GEN_TESTPAT_EN
  input  logic                  test_mode,
`endif
  output logic                  pix_ce,
  output logic [10:0]           x,
  output logic [10:0]           y,
  output logic                  active,
  output logic                  line_start,
  output logic                  frame_start,
  output logic                  VGA_CLK,
  output logic [7:0]            VGA_R,
  output logic [7:0]            VGA_G,
  output logic [7:0]            VGA_B,
  output logic                  VGA_HS,
  output logic                  VGA_VS,
  output logic                  VGA_BLANK_N,
  output logic                  VGA_SYNC_N
);

  localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [3:0]  DIV_HALF = 4'(CLK_DIV / 2);
  localparam logic [11:0] H_LAST   = 12'(H_SYNC + H_BACK + H_ACTIVE + H_FRONT - 1);
  localparam logic [11:0] V_LAST   = 12'(V_SYNC + V_BACK + V_ACTIVE + V_FRONT - 1);
  localparam logic [11:0] H_SYNC_E = 12'(H_SYNC);
  localparam logic [11:0] V_SYNC_E = 12'(V_SYNC);
  localparam logic [11:0] H_AS     = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] H_AE     = 12'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [11:0] V_AS     = 12'(V_SYNC + V_BACK);
  localparam logic [11:0] V_AE     = 12'(V_SYNC + V_BACK + V_ACTIVE);

`ifdef VGA_TIMING_GEN_TESTPAT_EN
  localparam int unsigned BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  typedef struct packed {
    logic       act;
    logic       hs;
    logic       vs;
    logic [2:0] bar;
  } pix_t;
`else
  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
  } pix_t;
`endif

  // Replicate a COLOR_BITS value across 8 bits, MSB first.
  function automatic logic [7:0] widen(input logic [COLOR_BITS-1:0] c);
    return 8'({8{c}} >> (8 * COLOR_BITS - 8));
  endfunction

  logic [3:0]  div_q, div_d;
  logic [11:0] h_q, v_q, h_d, v_d;
  logic [10:0] x_q, y_q, x_d, y_d;
  logic        act_q, act_d;
  pix_t        cur, tap;
  logic [7:0]  r8, g8, b8;

  // Pixel-rate divider: pix_ce marks the last CLOCK_50 cycle of each pixel.
  always_comb div_d = (div_q == DIV_LAST) ? '0 : div_q + 4'd1;
  assign pix_ce = (div_q == DIV_LAST);

  // VGA_CLK is registered from the next divider value so it tracks div
  // exactly; outputs update on its falling edge, mid-way from its rising edge.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      div_q   <= '0;
      VGA_CLK <= 1'b0;
    end else begin
      div_q   <= div_d;
      VGA_CLK <= (div_d >= DIV_HALF);
    end
  end

  // Next raster position and its active-area coordinates.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (!enable) begin
      h_d = '0;
      v_d = '0;
    end else if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 12'd1;
    end else begin
      h_d = h_q + 12'd1;
    end
    act_d = enable && (h_d >= H_AS) && (h_d < H_AE) && (v_d >= V_AS) && (v_d < V_AE);
    x_d   = act_d ? 11'(h_d - H_AS) : '1;
    y_d   = act_d ? 11'(v_d - V_AS) : '1;
  end

  // Raster counters and coordinates advance together on the pixel tick.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      h_q   <= '0;
      v_q   <= '0;
      x_q   <= '1;
      y_q   <= '1;
      act_q <= 1'b0;
    end else if (pix_ce) begin
      h_q   <= h_d;
      v_q   <= v_d;
      x_q   <= x_d;
      y_q   <= y_d;
      act_q <= act_d;
    end
  end

  assign x           = enable ? x_q : '1;
  assign y           = enable ? y_q : '1;
  assign active      = enable & act_q;
  assign line_start  = pix_ce & enable & (h_q == '0);
  assign frame_start = line_start & (v_q == '0);
  assign VGA_SYNC_N  = 1'b1;

  // Flags for the pixel currently being requested; all zero means blank.
  always_comb begin
    cur     = '0;
    cur.act = active;
    cur.hs  = enable && (h_q < H_SYNC_E);
    cur.vs  = enable && (v_q < V_SYNC_E);
`ifdef VGA_TIMING_GEN_TESTPAT_EN
    cur.bar = ((x_q / 11'(BAR_W)) > 11'd7) ? 3'd7 : 3'((x_q / 11'(BAR_W)));
`endif
  end

  generate
    if (PIPE_LAT == 0) begin : g_nopipe
      assign tap = cur;
    end else begin : g_pipe
      localparam int unsigned PW = $bits(pix_t);
      logic [PIPE_LAT*PW-1:0]     sh_q;
      logic [(PIPE_LAT+1)*PW-1:0] sh_cat;
      assign sh_cat = {sh_q, cur};
      // Delay line: the oldest entry matches the colour now on R/G/B.
      always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) sh_q <= '0;
        else if (pix_ce) sh_q <= sh_cat[PIPE_LAT*PW-1:0];
      end
      assign tap = pix_t'(sh_cat[(PIPE_LAT+1)*PW-1 -: PW]);
    end
  endgenerate

  // Colour source: expanded input, or bars when the test pattern is selected.
  always_comb begin
    r8 = widen(R);
    g8 = widen(G);
    b8 = widen(B);
`ifdef VGA_TIMING_GEN_TESTPAT_EN
    if (test_mode) begin
      r8 = {8{tap.bar[2]}};
      g8 = {8{tap.bar[1]}};
      b8 = {8{tap.bar[0]}};
    end
`endif
  end

  // Final output register: one full pixel period per value, blanked outside.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      VGA_BLANK_N <= 1'b0;
      VGA_HS      <= ~HS_POL;
      VGA_VS      <= ~VS_POL;
    end else if (pix_ce) begin
      VGA_R       <= tap.act ? r8 : '0;
      VGA_G       <= tap.act ? g8 : '0;
      VGA_B       <= tap.act ? b8 : '0;
      VGA_BLANK_N <= tap.act;
      VGA_HS      <= tap.hs ? HS_POL : ~HS_POL;
      VGA_VS      <= tap.vs ? VS_POL : ~VS_POL;
    end
  end

endmodule
